// File: rtl/div_result_bcd_display.sv
// div_result_bcd_display
// Accepts one quotient/remainder pair from the divider, converts both values
// to three BCD digits with an 8-iteration double-dabble engine, holds the
// result and scans it onto a six-digit active-low seven-segment display.

module div_result_bcd_display #(
    parameter int SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  quo,
    input  logic [7:0]  rem,
    output logic        out_valid,
    output logic [11:0] quo_bcd,
    output logic [11:0] rem_bcd,
    output logic [6:0]  seg,
    output logic [5:0]  an
);

    // Counter width is kept at one bit minimum so SCAN_DIV=1 still builds.
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_r;
    logic [19:0]        quo_work_r;
    logic [19:0]        rem_work_r;
    logic [2:0]         iter_r;
    logic [11:0]        quo_bcd_r;
    logic [11:0]        rem_bcd_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [CNT_W-1:0]   scan_cnt_r;
    logic [2:0]         scan_idx_r;
    logic [3:0]         digit_s;
    logic [19:0]        quo_next_s;
    logic [19:0]        rem_next_s;

    // One double-dabble iteration on {bcd[11:0], bin[7:0]}:
    // add 3 to each BCD nibble >= 5, then shift the whole word left.
    function automatic logic [19:0] dabble_step(input logic [19:0] w);
        logic [19:0] a;
        a = w;
        for (int i = 0; i < 3; i++) begin
            if (a[8 + 4*i +: 4] >= 4'd5) begin
                a[8 + 4*i +: 4] = a[8 + 4*i +: 4] + 4'd3;
            end else begin
                a[8 + 4*i +: 4] = a[8 + 4*i +: 4];
            end
        end
        return {a[18:0], 1'b0};
    endfunction

    // Active-low gfedcba pattern for one BCD digit; non-decimal codes blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Next value of both working registers for the current iteration.
    always_comb begin
        quo_next_s = dabble_step(quo_work_r);
        rem_next_s = dabble_step(rem_work_r);
    end

    // Conversion FSM: accept in IDLE, iterate 8 times in SHIFT, pulse in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            quo_work_r  <= 20'd0;
            rem_work_r  <= 20'd0;
            iter_r      <= 3'd0;
            quo_bcd_r   <= 12'd0;
            rem_bcd_r   <= 12'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    out_valid_r <= 1'b0;
                    if (in_valid) begin
                        quo_work_r <= {12'd0, quo};
                        rem_work_r <= {12'd0, rem};
                        iter_r     <= 3'd0;
                        in_ready_r <= 1'b0;
                        state_r    <= SHIFT;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                SHIFT: begin
                    quo_work_r <= quo_next_s;
                    rem_work_r <= rem_next_s;
                    iter_r     <= iter_r + 3'd1;
                    if (iter_r == 3'd7) begin
                        quo_bcd_r   <= quo_next_s[19:8];
                        rem_bcd_r   <= rem_next_s[19:8];
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        out_valid_r <= 1'b0;
                    end
                end
                DONE: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    // Free-running display scan: each digit is enabled for SCAN_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_r <= '0;
            scan_idx_r <= 3'd0;
        end else if (scan_cnt_r == CNT_LAST) begin
            scan_cnt_r <= '0;
            scan_idx_r <= (scan_idx_r == 3'd5) ? 3'd0 : scan_idx_r + 3'd1;
        end else begin
            scan_cnt_r <= scan_cnt_r + CNT_W'(1);
        end
    end

    // Select the held digit addressed by the scan index.
    always_comb begin
        digit_s = 4'hF;
        case (scan_idx_r)
            3'd0:    digit_s = rem_bcd_r[3:0];
            3'd1:    digit_s = rem_bcd_r[7:4];
            3'd2:    digit_s = rem_bcd_r[11:8];
            3'd3:    digit_s = quo_bcd_r[3:0];
            3'd4:    digit_s = quo_bcd_r[7:4];
            3'd5:    digit_s = quo_bcd_r[11:8];
            default: digit_s = 4'hF;
        endcase
    end

    // Digit enable and segment drive, decoded from the registered index.
    always_comb begin
        an  = ~(6'b000001 << scan_idx_r);
        seg = seg_decode(digit_s);
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign quo_bcd   = quo_bcd_r;
    assign rem_bcd   = rem_bcd_r;

endmodule
